// File: rtl/matrix_ops_pkg.sv
// Shared matrix ISA definitions: opcode enum, field positions, decoded command
// record, and the legality/normalisation helpers also used by the assembler model.
package matrix_ops_pkg;

  typedef enum logic [2:0] {
    MATRIX_NONE = 3'd0,
    MLOAD       = 3'd1,
    MSTORE      = 3'd2,
    MMULT       = 3'd3,
    MADD        = 3'd4,
    MSUB        = 3'd5,
    MTRANSPOSE  = 3'd6
  } matrix_op_t;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 29;
  localparam int DST_LSB    = 25;
  localparam int SRCA_LSB   = 21;
  localparam int SRCB_LSB   = 17;
  localparam int REG_W      = 4;
  localparam int CMD_ADDR_W = 17;

  typedef struct packed {
    matrix_op_t            op;
    logic [REG_W-1:0]      dst;
    logic [REG_W-1:0]      src_a;
    logic [REG_W-1:0]      src_b;
    logic [CMD_ADDR_W-1:0] addr;
  } matrix_cmd_t;

  function automatic logic is_legal(input logic [31:0] instr);
    logic [2:0]       op;
    logic [REG_W-1:0] dst, src_a, src_b;
    op    = instr[OP_MSB:OP_LSB];
    dst   = instr[DST_LSB  +: REG_W];
    src_a = instr[SRCA_LSB +: REG_W];
    src_b = instr[SRCB_LSB +: REG_W];
    case (op)
      MLOAD, MSTORE, MADD, MSUB, MTRANSPOSE: is_legal = 1'b1;
      // In-place multiply would overwrite an operand mid-computation.
      MMULT:   is_legal = (dst != src_a) && (dst != src_b);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Keeps only the fields an opcode actually uses; everything else reads as zero.
  function automatic matrix_cmd_t normalize(input logic [31:0] instr);
    matrix_cmd_t cmd;
    cmd = '0;
    case (instr[OP_MSB:OP_LSB])
      MLOAD: begin
        cmd.op   = MLOAD;
        cmd.dst  = instr[DST_LSB +: REG_W];
        cmd.addr = instr[CMD_ADDR_W-1:0];
      end
      MSTORE: begin
        cmd.op    = MSTORE;
        cmd.src_a = instr[SRCA_LSB +: REG_W];
        cmd.addr  = instr[CMD_ADDR_W-1:0];
      end
      MMULT, MADD, MSUB: begin
        cmd.op    = matrix_op_t'(instr[OP_MSB:OP_LSB]);
        cmd.dst   = instr[DST_LSB  +: REG_W];
        cmd.src_a = instr[SRCA_LSB +: REG_W];
        cmd.src_b = instr[SRCB_LSB +: REG_W];
      end
      MTRANSPOSE: begin
        cmd.op    = MTRANSPOSE;
        cmd.dst   = instr[DST_LSB  +: REG_W];
        cmd.src_a = instr[SRCA_LSB +: REG_W];
      end
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/matrix_cmd_fifo.sv
// Decoded-command FIFO with a registered head so the consumer sees no RAM read path
// and the last command stays visible after the FIFO drains.
module matrix_cmd_fifo
  import matrix_ops_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  matrix_cmd_t              din,
  input  logic                     pop,
  input  logic                     flush,
  output matrix_cmd_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LVL_W = IDX_W + 1;

  // The extra pointer MSB separates full (difference == DEPTH) from empty (== 0).
  logic [LVL_W-1:0] wr_ptr, rd_ptr, rd_next, lvl_next;
  matrix_cmd_t      mem [DEPTH];
  matrix_cmd_t      head_q;
  logic             push_ok, pop_ok;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign rd_next  = rd_ptr + LVL_W'(pop_ok);
  assign lvl_next = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
  assign dout     = head_q;

  // NOTE: storage array carries no reset; only pointers and the head register need
  // a defined value, which keeps the array mappable onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[IDX_W-1:0]] <= din;
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + LVL_W'(push_ok);
      rd_ptr <= rd_next;
    end
  end

  // The new head is the incoming word only when it will be the sole entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (!flush && lvl_next != '0) begin
      if (push_ok && rd_next[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) head_q <= din;
      else                                                    head_q <= mem[rd_next[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/matrix_instr_decoder.sv
// Matrix accelerator front end: decodes ISA words, drops and counts illegal ones,
// and queues legal commands for the execution controller.
module matrix_instr_decoder
  import matrix_ops_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 17,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [31:0]            instr_data,
  input  logic                   flush,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [2:0]             cmd_op,
  output logic [3:0]             cmd_dst,
  output logic [3:0]             cmd_src_a,
  output logic [3:0]             cmd_src_b,
  output logic [ADDR_W-1:0]      cmd_addr,
  output logic                   illegal_pulse,
  output logic [ERR_CNT_W-1:0]   illegal_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  matrix_cmd_t dec_cmd, head;
  logic        dec_legal, accept, full, empty;

  assign dec_legal = is_legal(instr_data);
  assign dec_cmd   = normalize(instr_data);

  // Ready depends only on FIFO state; illegal words are accepted too so the host never stalls.
  assign instr_ready = !full;
  assign accept      = instr_valid && instr_ready;

  matrix_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && dec_legal),
    .din   (dec_cmd),
    .pop   (cmd_valid && cmd_ready),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign cmd_valid = !empty;
  assign cmd_op    = head.op;
  assign cmd_dst   = head.dst;
  assign cmd_src_a = head.src_a;
  assign cmd_src_b = head.src_b;
  // Instruction words carry a 17-bit address; narrower configurations keep the low bits.
  assign cmd_addr  = head.addr[ADDR_W-1:0];

  // Counting continues through flush; only reset clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_pulse <= 1'b0;
      illegal_cnt   <= '0;
    end else begin
      illegal_pulse <= accept && !dec_legal;
      if (accept && !dec_legal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_instr_decoder.sv
// Directed bench for matrix_instr_decoder: vector table plus FIFO, flush, reset and
// counter-saturation sequences; a second instance uses a 2-bit error counter.
module tb_matrix_instr_decoder;
  import matrix_ops_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, flush, cmd_ready;
  logic [31:0] instr_data;

  logic        instr_ready, cmd_valid, illegal_pulse;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_dst, cmd_src_a, cmd_src_b;
  logic [16:0] cmd_addr;
  logic [7:0]  illegal_cnt;
  logic [2:0]  fifo_level;

  logic        instr_ready_s, cmd_valid_s, illegal_pulse_s;
  logic [2:0]  cmd_op_s;
  logic [3:0]  cmd_dst_s, cmd_src_a_s, cmd_src_b_s;
  logic [16:0] cmd_addr_s;
  logic [1:0]  illegal_cnt_s;
  logic [2:0]  fifo_level_s;

  always #5 clk = ~clk;

  matrix_instr_decoder #(.DEPTH(DEPTH), .ADDR_W(17), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_addr(cmd_addr), .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt),
    .fifo_level(fifo_level)
  );

  matrix_instr_decoder #(.DEPTH(DEPTH), .ADDR_W(17), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready_s),
    .instr_data(instr_data), .flush(flush), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op_s), .cmd_dst(cmd_dst_s), .cmd_src_a(cmd_src_a_s), .cmd_src_b(cmd_src_b_s),
    .cmd_addr(cmd_addr_s), .illegal_pulse(illegal_pulse_s), .illegal_cnt(illegal_cnt_s),
    .fifo_level(fifo_level_s)
  );

  typedef struct {
    logic [31:0] instr;
    bit          legal;
    logic [2:0]  op;
    logic [3:0]  dst, src_a, src_b;
    logic [16:0] addr;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] dst,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [16:0] addr);
    return {op, dst, a, b, addr};
  endfunction

  vec_t vecs [11];
  int   q [$];
  int   k;

  initial begin
    vecs[0]  = '{mk(3'd4, 4'd2, 4'd3, 4'd4, 17'h0),     1, 3'd4, 4'd2, 4'd3, 4'd4, 17'h0};
    vecs[1]  = '{mk(3'd1, 4'd1, 4'hF, 4'hF, 17'h1ABCD), 1, 3'd1, 4'd1, 4'd0, 4'd0, 17'h1ABCD};
    vecs[2]  = '{mk(3'd2, 4'd9, 4'd6, 4'd3, 17'h00123), 1, 3'd2, 4'd0, 4'd6, 4'd0, 17'h00123};
    vecs[3]  = '{mk(3'd3, 4'd1, 4'd2, 4'd3, 17'h00055), 1, 3'd3, 4'd1, 4'd2, 4'd3, 17'h0};
    vecs[4]  = '{mk(3'd5, 4'd7, 4'd8, 4'd9, 17'h1FFFF), 1, 3'd5, 4'd7, 4'd8, 4'd9, 17'h0};
    vecs[5]  = '{mk(3'd6, 4'hA, 4'hB, 4'hC, 17'h00001), 1, 3'd6, 4'hA, 4'hB, 4'd0, 17'h0};
    vecs[6]  = '{mk(3'd4, 4'd3, 4'd3, 4'd3, 17'h0),     1, 3'd4, 4'd3, 4'd3, 4'd3, 17'h0};
    vecs[7]  = '{mk(3'd3, 4'd5, 4'd5, 4'd1, 17'h0),     0, 3'd0, 4'd0, 4'd0, 4'd0, 17'h0};
    vecs[8]  = '{mk(3'd3, 4'd5, 4'd1, 4'd5, 17'h0),     0, 3'd0, 4'd0, 4'd0, 4'd0, 17'h0};
    vecs[9]  = '{mk(3'd0, 4'd1, 4'd2, 4'd3, 17'h0),     0, 3'd0, 4'd0, 4'd0, 4'd0, 17'h0};
    vecs[10] = '{mk(3'd7, 4'd1, 4'd2, 4'd3, 17'h0),     0, 3'd0, 4'd0, 4'd0, 4'd0, 17'h0};

    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; flush = 1'b0; cmd_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    check("rst_instr_ready", instr_ready, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_fields", {cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_addr}, 0);
    check("rst_pulse", illegal_pulse, 0);
    check("rst_cnt", illegal_cnt, 0);
    check("rst_level", fifo_level, 0);

    for (int i = 0; i < 11; i++) begin
      instr_valid = 1'b1;
      instr_data  = vecs[i].instr;
      tick;
      instr_valid = 1'b0;
      if (vecs[i].legal) begin
        check("vec_valid", cmd_valid, 1);
        check("vec_op", cmd_op, vecs[i].op);
        check("vec_dst", cmd_dst, vecs[i].dst);
        check("vec_src_a", cmd_src_a, vecs[i].src_a);
        check("vec_src_b", cmd_src_b, vecs[i].src_b);
        check("vec_addr", cmd_addr, vecs[i].addr);
        check("vec_no_pulse", illegal_pulse, 0);
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        check("vec_drained", cmd_valid, 0);
      end else begin
        exp_cnt++;
        check("vec_ill_valid", cmd_valid, 0);
        check("vec_ill_pulse", illegal_pulse, 1);
        check("vec_ill_cnt", illegal_cnt, exp_cnt);
        tick;
        check("vec_ill_pulse_end", illegal_pulse, 0);
      end
    end

    // Three illegal words back to back: three consecutive pulse cycles.
    instr_valid = 1'b1;
    instr_data = mk(3'd0, 4'd1, 4'd2, 4'd3, 17'h0);  tick; check("b2b_pulse0", illegal_pulse, 1);
    instr_data = mk(3'd7, 4'd1, 4'd2, 4'd3, 17'h0);  tick; check("b2b_pulse1", illegal_pulse, 1);
    instr_data = mk(3'd3, 4'd5, 4'd5, 4'd1, 17'h0);  tick; check("b2b_pulse2", illegal_pulse, 1);
    instr_valid = 1'b0;
    exp_cnt += 3;
    tick;
    check("b2b_pulse_end", illegal_pulse, 0);
    check("b2b_cnt", illegal_cnt, exp_cnt);
    check("b2b_no_cmd", cmd_valid, 0);

    // Fill past DEPTH with the consumer stalled, then drain in order.
    for (int i = 0; i <= DEPTH; i++) begin
      instr_valid = 1'b1;
      instr_data  = mk(3'd4, 4'(i), 4'(i + 8), 4'd1, 17'h0);
      check("fill_ready", instr_ready, (i < DEPTH) ? 1 : 0);
      tick;
    end
    instr_valid = 1'b0;
    check("full_level", fifo_level, DEPTH);
    check("full_ready", instr_ready, 0);
    cmd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_dst", cmd_dst, i);
      check("drain_src_a", cmd_src_a, i + 8);
      tick;
    end
    cmd_ready = 1'b0;
    check("drain_empty", cmd_valid, 0);
    check("drain_level", fifo_level, 0);
    check("empty_hold_dst", cmd_dst, DEPTH - 1);

    // Steady push+pop at level 2 across several pointer wraps.
    k = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_data = mk(3'd5, 4'(k), 4'd0, 4'd0, 17'h0);
      q.push_back(k % 16);
      k++;
      tick;
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr_data = mk(3'd5, 4'(k), 4'd0, 4'd0, 17'h0);
      check("stream_level", fifo_level, 2);
      check("stream_head", cmd_dst, q[0]);
      tick;
      void'(q.pop_front());
      q.push_back(k % 16);
      k++;
    end
    check("stream_level_end", fifo_level, 2);
    check("stream_head_end", cmd_dst, q[0]);

    flush = 1'b1;
    tick;
    flush = 1'b0; instr_valid = 1'b0; cmd_ready = 1'b0;
    check("flush_level", fifo_level, 0);
    check("flush_valid", cmd_valid, 0);
    check("flush_ready", instr_ready, 1);

    flush = 1'b1; instr_valid = 1'b1; instr_data = mk(3'd7, 4'd0, 4'd0, 4'd0, 17'h0);
    tick;
    flush = 1'b0; instr_valid = 1'b0;
    exp_cnt++;
    check("flush_ill_cnt", illegal_cnt, exp_cnt);
    check("flush_ill_pulse", illegal_pulse, 1);
    check("flush_ill_level", fifo_level, 0);

    // Reset with three commands buffered.
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_data = mk(3'd1, 4'(i + 1), 4'd0, 4'd0, 17'(i + 100));
      tick;
    end
    instr_valid = 1'b0;
    check("pre_rst_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", cmd_valid, 0);
    check("async_rst_level", fifo_level, 0);
    tick;
    rst_n = 1'b1;
    tick;
    exp_cnt = 0;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_cnt", illegal_cnt, 0);
    check("mid_rst_fields", {cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_addr}, 0);

    // Five illegal words: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    instr_valid = 1'b1;
    instr_data  = mk(3'd7, 4'd2, 4'd2, 4'd2, 17'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      exp_cnt++;
      check("sat_cnt_wide", illegal_cnt, exp_cnt);
      check("sat_cnt_narrow", illegal_cnt_s, (i + 1 > 3) ? 3 : i + 1);
    end
    instr_valid = 1'b0;
    check("sat_pulse", illegal_pulse_s, 1);
    check("sat_valid", cmd_valid_s, 0);
    check("sat_level", fifo_level_s, 0);
    check("sat_ready", instr_ready_s, 1);
    check("sat_fields", {cmd_op_s, cmd_dst_s, cmd_src_a_s, cmd_src_b_s, cmd_addr_s}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
